// File: rtl/sdc_rd_capture.sv
// sdc_rd_capture: read-data capture and valid generator for the SDRAM data path.
// A shift pipe delays each read/terminate command by the latched CAS latency.
// A beat counter then turns the delayed command into a run of valid beats.
// When a new read or a terminate cuts the previous burst short, the block
// reports the truncation with a one-cycle pulse.

module sdc_rd_capture #(
  parameter int DW     = 64,
  parameter int MAX_CL = 4,
  parameter int LENW   = 8
) (
  input  logic            clk,
  input  logic            rst2,
  input  logic [2:0]      cas_lat,
  input  logic [2:0]      burst_len,
  input  logic [LENW-1:0] rd_len,
  input  logic            rd_cmd,
  input  logic            rd_term,
  input  logic [DW-1:0]   sdc_dq_i,
  output logic [DW-1:0]   u_data_o,
  output logic            u_data_valid,
  output logic            u_rd_last,
  output logic            u_rd_trunc,
  output logic            rd_busy
);

  localparam int CLW = $clog2(MAX_CL + 1);
  localparam int CW  = LENW + 1;

  logic [CLW-1:0]    r_cl;
  logic [MAX_CL-1:0] r_pipe_cmd;
  logic [MAX_CL-1:0] r_pipe_term;
  logic [CW-1:0]     r_pipe_beats [MAX_CL];
  logic [CW-1:0]     r_cnt;

  logic [CLW-1:0]    w_cl_clamp;
  logic [CW-1:0]     w_beats_dec;
  logic              w_tap_cmd;
  logic              w_tap_term;
  logic [CW-1:0]     w_tap_beats;
  logic              w_beat;
  logic              w_last;
  logic              w_trunc;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_busy;

  // Clamp the requested CAS latency into the supported 1..MAX_CL range.
  always_comb begin
    w_cl_clamp = CLW'(1);
    if (cas_lat == 3'd0) begin
      w_cl_clamp = CLW'(1);
    end else if (32'(cas_lat) > 32'(MAX_CL)) begin
      w_cl_clamp = CLW'(MAX_CL);
    end else begin
      w_cl_clamp = CLW'(cas_lat);
    end
  end

  // Decode the burst-length code into a beat count; page mode uses rd_len (0 = 2^LENW).
  always_comb begin
    w_beats_dec = CW'(1);
    case (burst_len)
      3'd0: w_beats_dec = CW'(1);
      3'd1: w_beats_dec = CW'(2);
      3'd2: w_beats_dec = CW'(4);
      3'd3: w_beats_dec = CW'(8);
      3'd7: begin
        if (rd_len == {LENW{1'b0}}) begin
          w_beats_dec = {1'b1, {LENW{1'b0}}};
        end else begin
          w_beats_dec = {1'b0, rd_len};
        end
      end
      default: w_beats_dec = CW'(1);
    endcase
  end

  // Select the pipe stage addressed by the latched CAS latency.
  always_comb begin
    w_tap_cmd   = 1'b0;
    w_tap_term  = 1'b0;
    w_tap_beats = {CW{1'b0}};
    for (int i = 0; i < MAX_CL; i++) begin
      w_tap_cmd   = w_tap_cmd  | ((r_cl == CLW'(i + 1)) & r_pipe_cmd[i]);
      w_tap_term  = w_tap_term | ((r_cl == CLW'(i + 1)) & r_pipe_term[i]);
      w_tap_beats = w_tap_beats | ((r_cl == CLW'(i + 1)) ? r_pipe_beats[i] : {CW{1'b0}});
    end
  end

  // Beat engine: a new command wins over a terminate, which wins over burst continuation.
  always_comb begin
    w_beat    = 1'b0;
    w_last    = 1'b0;
    w_trunc   = 1'b0;
    w_cnt_nxt = r_cnt;
    if (w_tap_cmd) begin
      w_beat    = 1'b1;
      w_trunc   = (r_cnt != {CW{1'b0}});
      w_cnt_nxt = w_tap_beats - CW'(1);
      w_last    = (w_tap_beats == CW'(1));
    end else if (w_tap_term && (r_cnt != {CW{1'b0}})) begin
      w_cnt_nxt = {CW{1'b0}};
      w_trunc   = 1'b1;
    end else if (r_cnt != {CW{1'b0}}) begin
      w_beat    = 1'b1;
      w_cnt_nxt = r_cnt - CW'(1);
      w_last    = (r_cnt == CW'(1));
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Busy is derived from registered state only, so the pad direction sees a clean signal.
  assign w_busy  = (|r_pipe_cmd) | (r_cnt != {CW{1'b0}});
  assign rd_busy = w_busy;

  // Latency pipe: stage 1 captures the command inputs every clock and the rest shift along.
  always_ff @(posedge clk or posedge rst2) begin
    if (rst2) begin
      r_pipe_cmd  <= {MAX_CL{1'b0}};
      r_pipe_term <= {MAX_CL{1'b0}};
      for (int i = 0; i < MAX_CL; i++) begin
        r_pipe_beats[i] <= {CW{1'b0}};
      end
    end else begin
      r_pipe_cmd      <= {r_pipe_cmd[MAX_CL-2:0], rd_cmd};
      r_pipe_term     <= {r_pipe_term[MAX_CL-2:0], rd_term};
      r_pipe_beats[0] <= w_beats_dec;
      for (int i = 1; i < MAX_CL; i++) begin
        r_pipe_beats[i] <= r_pipe_beats[i-1];
      end
    end
  end

  // Latency only changes when nothing is in flight, so queued reads keep their timing.
  always_ff @(posedge clk or posedge rst2) begin
    if (rst2) begin
      r_cl <= CLW'(1);
    end else if (!w_busy && !rd_cmd) begin
      r_cl <= w_cl_clamp;
    end
  end

  // Beat counter and registered host-side outputs; data holds between beats.
  always_ff @(posedge clk or posedge rst2) begin
    if (rst2) begin
      r_cnt        <= {CW{1'b0}};
      u_data_o     <= {DW{1'b0}};
      u_data_valid <= 1'b0;
      u_rd_last    <= 1'b0;
      u_rd_trunc   <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      u_data_valid <= w_beat;
      u_rd_last    <= w_last;
      u_rd_trunc   <= w_trunc;
      if (w_beat) begin
        u_data_o <= sdc_dq_i;
      end
    end
  end

endmodule

// File: doc/sdc_rd_capture.md
# sdc_rd_capture

Parametrised read-data capture and valid generator for the SDRAM controller's single-clock data path. It replaces the fixed CAS-2/3 and BL-2/4/8 valid decode with a programmable latency pipe, a burst beat counter, page-mode length and burst-terminate handling, and read-interrupt (truncation) reporting. It sits between the `sdc_dq` pad buffers and the host read interface, next to the command sequencer that issues `rd_cmd`/`rd_term`.

## Interface
- `DW`, 64, SDRAM data width; also the host data width.
- `MAX_CL`, 4, largest supported CAS latency in clocks (≥2).
- `LENW`, 8, page-mode length width.

Ports:
- `clk`  in  1  controller clock; all logic on its rising edge.
- `rst2`  in  1  reset, asynchronous, active-high.
- `cas_lat`  in  3  CAS latency in clocks; 0 acts as 1, values above `MAX_CL` act as `MAX_CL`.
- `burst_len`  in  3  0 = 1 beat, 1 = 2, 2 = 4, 3 = 8, 7 = page; codes 4–6 act as 1 beat.
- `rd_len`  in  LENW  beat count for page mode, sampled with `rd_cmd`; 0 means 2^LENW.
- `rd_cmd`  in  1  read command issued to DRAM this cycle.
- `rd_term`  in  1  burst-terminate command issued this cycle.
- `sdc_dq_i`  in  DW  data from the pad input buffers.
- `u_data_o`  out  DW  captured read data.
- `u_data_valid`  out  1  `u_data_o` is valid this cycle.
- `u_rd_last`  out  1  last beat of a burst that completed normally.
- `u_rd_trunc`  out  1  one-cycle pulse: the preceding burst ended early.
- `rd_busy`  out  1  read in flight; the pad direction control uses it to hold `sdc_dq` in input mode.

## Operation
- Latency pipe: `MAX_CL` stages. Each stage holds {cmd, term, beats}. Stage 1 loads {`rd_cmd`, `rd_term`, decoded length} every clock. The tap is the stage indexed by the latched `cas_lat` (`cl_q`).
- `cl_q` loads the clamped `cas_lat` only in cycles where `rd_busy` = 0 and `rd_cmd` = 0. Changes made while busy take effect after the pipe drains.
- Beat engine, per cycle, in priority order:
  - Tap cmd: a beat is active. If `cnt` ≠ 0, the previous burst is truncated. `cnt` ← beats−1.
  - Else tap term with `cnt` ≠ 0: no beat this cycle; `cnt` ← 0; truncation is flagged.
  - Else `cnt` ≠ 0: a beat is active; `cnt` ← `cnt`−1.
  - A term arriving at the tap together with a cmd is discarded. A term arriving while idle is ignored.
- Active beat: `u_data_o` ← `sdc_dq_i`, and `u_data_valid` ← 1 on the next clock.
- Last beat is the active beat with (tap cmd and beats = 1) or (no tap cmd and `cnt` = 1). It drives `u_rd_last` ← 1 on the next clock.
- `u_rd_trunc` ← 1 for the clock following a truncation event:
  - For a cmd truncation it coincides with the first valid beat of the new burst.
  - For a term truncation `u_data_valid` is 0 in that cycle.
- `u_data_o` holds its value when no beat is active.
- `cnt` is LENW+1 bits wide so that 2^LENW is representable.
- `rd_busy` = OR of all pipe cmd bits, or `cnt` ≠ 0; it is built from registers only.

## Timing
- Reset values: `u_data_o` = 0, `u_data_valid` = 0, `u_rd_last` = 0, `u_rd_trunc` = 0, `rd_busy` = 0, pipe cleared, `cnt` = 0, `cl_q` = 1.
- Reset mid-burst aborts the burst silently: no last, no trunc.
- The DRAM drives beat 0 in cycle C + `cl_q`, where C is the `rd_cmd` cycle. `u_data_valid` is first high in cycle C + `cl_q` + 1.
- An N-beat burst gives N consecutive valid cycles. `u_rd_last` is high with the final one.
- A following `rd_cmd` issued exactly N cycles later produces a gap-free valid stream.
- A term at cycle T: the first suppressed beat is the one driven in T + `cl_q`. The `u_rd_trunc` pulse falls in T + `cl_q` + 1.
- `rd_busy` rises in C+1 and falls the cycle after the last pipe cmd bit leaves and `cnt` reaches 0.

## Test plan
- Reset with `rd_cmd` held at 1 → all outputs 0 during reset. After release, pipe behaviour starts from `cl_q` = 1.
- `cas_lat` = 2, `burst_len` = 2 (4 beats), `rd_cmd` at cycle 10, `sdc_dq_i` = A0..A3 in cycles 12–15 → valid in cycles 13–16 with data A0..A3; `u_rd_last` in cycle 16 only; `rd_busy` in cycles 11–15.
- `cas_lat` = 3, `burst_len` = 3 (8 beats), `rd_cmd` at cycles 10 and 18 → valid in cycles 14–29 continuous; `u_rd_last` in cycles 21 and 29; no trunc.
- `cas_lat` = 2, 8-beat burst, second `rd_cmd` 3 cycles after the first → 3 beats of the first burst with no last; `u_rd_trunc` together with the first beat of the second burst; then 8 beats with last.
- Page mode:
  - `rd_len` = 5, `rd_term` 3 cycles after `rd_cmd`, `cas_lat` = 2 → 3 valid beats, then a trunc pulse with valid = 0, no last.
  - `rd_len` = 0 → 256 beats with last on the 256th.
- `cas_lat` changed from 2 to 4 mid-burst → current and queued reads still use 2. `cas_lat` = 0 → behaves as 1. Async reset asserted mid-burst → outputs 0 immediately.
